erasable_ram_sync: RTL and testbench
====================================

// Module: erasable_ram_sync
// PURPOSE
//  Clocked, parametrised erasable-memory model; next generation of the asynchronous 16-bit byte-laned RAM model.
//  Single-port word store with valid/ready request handshake, per-byte write enables and a pipelined read return.
//  Includes a post-reset clear sweep and sticky error flags; a write+read collision no longer ends the simulation.
//  Sits between the erasable-memory interface logic and the simulation/FPGA memory array.
// PARAMETERS
//  DATA_W          16        word width in bits (>=8); lanes are 8 bits each, top lane holds the remainder
//  ADDR_W          11        request address width
//  DEPTH           2048      number of words (<= 2**ADDR_W)
//  INIT_WORD       16'o40000 value every word holds after the clear sweep
//  READ_LAT        1         cycles from read accept to rdata_valid (1..4)
//  CLEAR_ON_RESET  1         1: run clear sweep after reset; 0: go straight to IDLE, contents kept
// PORTS
//  SIM_CLK      in   1                  clock, all state on rising edge
//  SIM_RST      in   1                  asynchronous reset, active high
//  req_valid    in   1                  request present
//  req_ready    out  1                  block accepts request this cycle
//  req_rd       in   1                  read request
//  req_wr       in   1                  write request
//  req_addr     in   ADDR_W             word address
//  req_wdata    in   DATA_W             write data
//  req_be       in   (DATA_W+7)/8       byte-lane write enables, bit0 = bits[7:0]
//  rdata        out  DATA_W             read data, valid only while rdata_valid
//  rdata_valid  out  1                  one-cycle pulse per accepted read
//  busy         out  1                  clear sweep in progress
//  err_collide  out  1                  sticky: request with req_rd and req_wr both set
//  err_range    out  1                  sticky: accepted request with req_addr >= DEPTH
//  err_clr      in   1                  synchronous clear of both sticky error flags
// BEHAVIOUR
//  - Reset (async): state=CLEAR (CLEAR_ON_RESET=1) else IDLE; sweep ptr=0; req_ready=0, rdata=0, rdata_valid=0,
//    read pipeline emptied, err_* = 0, busy=CLEAR_ON_RESET. Memory contents are not touched by reset itself.
//  - CLEAR: one word per cycle, mem[ptr]<=INIT_WORD, ptr 0..DEPTH-1; busy=1, req_ready=0.
//    After writing DEPTH-1 -> IDLE the next cycle (busy low exactly DEPTH cycles after reset release).
//  - IDLE: req_ready=1. Accept = req_valid & req_ready at rising edge.
//  - Write accept: for each lane i with req_be[i]=1, mem[addr] lane i <= req_wdata lane i; other lanes keep value.
//    req_be=0 is a legal no-op write. No response pulse for writes.
//  - Read accept: rdata = mem[addr] as of that edge (after any write committed at an earlier edge);
//    rdata_valid pulses exactly READ_LAT cycles after the accept edge. Back-to-back reads every cycle allowed;
//    results return in order, one per cycle.
//  - Write at edge N, read same address at edge N+1: read returns the new data.
//  - req_valid with neither rd nor wr: accepted, ignored.
//  - Collision (rd & wr & valid & ready): no memory change, no rdata_valid, err_collide <= 1.
//  - Out of range (addr >= DEPTH): write discarded; read returns INIT_WORD with normal rdata_valid; err_range <= 1.
//  - err_clr and a new error in the same cycle: the flag ends set (set wins).
//  - Reset mid-sweep restarts the sweep at 0. Reset with reads in flight: pending rdata_valid pulses are dropped.
//  - rdata holds its last value between pulses.
// TESTING
//  1. Reset, DEPTH=2048 -> busy high 2048 cycles, req_ready low throughout; then read 0, 1023, 2047 -> 16'o40000 each.
//  2. Write addr 5 data 16'hA55A be=2'b11; read 5 next cycle -> rdata=16'hA55A, rdata_valid 1 cycle after accept.
//  3. Write addr 5 data 16'h1234 be=2'b01 over 16'hA55A -> read 5 returns 16'hA534; be=2'b10 16'hFF00 -> 16'hFF34.
//  4. Request rd=1, wr=1, addr 7, data 16'h0001 -> err_collide=1, mem[7] unchanged, no rdata_valid; err_clr -> 0.
//  5. READ_LAT=3, reads 1,2,3 on consecutive cycles -> three rdata_valid pulses cycles 3,4,5, data in order.
//  6. DEPTH=1000, ADDR_W=10: write 1010 -> discarded, err_range=1; assert SIM_RST at sweep ptr 500 -> sweep restarts at 0.

Source files
------------

// File: rtl/erasable_ram_sync.sv
// erasable_ram_sync: clocked single-port word store for the erasable-memory model.
// Requests use a valid/ready handshake, writes have per-byte lane enables and reads
// return through a READ_LAT-deep pipeline. After reset an optional sweep fills every
// word with INIT_WORD. Collisions and out-of-range accesses raise sticky error flags.
//
// Ports
//   SIM_CLK      in   clock, rising edge
//   SIM_RST      in   asynchronous reset, active high
//   req_valid    in   request present
//   req_ready    out  request accepted this cycle when high together with req_valid
//   req_rd       in   read request
//   req_wr       in   write request
//   req_addr     in   word address
//   req_wdata    in   write data
//   req_be       in   byte-lane write enables, bit0 = bits[7:0]
//   rdata        out  read data, meaningful while rdata_valid, held otherwise
//   rdata_valid  out  one-cycle pulse per accepted read
//   busy         out  clear sweep in progress
//   err_collide  out  sticky: accepted request with both rd and wr set
//   err_range    out  sticky: accepted access with req_addr >= DEPTH
//   err_clr      in   synchronous clear of both sticky flags (a new error wins)
module erasable_ram_sync #(
  parameter int unsigned        DATA_W         = 16,
  parameter int unsigned        ADDR_W         = 11,
  parameter int unsigned        DEPTH          = 2048,
  parameter logic [DATA_W-1:0]  INIT_WORD      = DATA_W'(16'o40000),
  parameter int unsigned        READ_LAT       = 1,
  parameter int unsigned        CLEAR_ON_RESET = 1
) (
  input  logic                      SIM_CLK,
  input  logic                      SIM_RST,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_rd,
  input  logic                      req_wr,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  input  logic [(DATA_W+7)/8-1:0]   req_be,
  output logic [DATA_W-1:0]         rdata,
  output logic                      rdata_valid,
  output logic                      busy,
  output logic                      err_collide,
  output logic                      err_range,
  input  logic                      err_clr
);

  localparam int unsigned NLANE = (DATA_W + 7) / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LAST  = READ_LAT - 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;

  logic                req_ready_q, req_ready_d;
  logic                busy_q, busy_d;
  logic                err_collide_q, err_collide_d;
  logic                err_range_q, err_range_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rdata_valid_q, rdata_valid_d;

  logic [READ_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [DATA_W-1:0]   pipe_dat_q [READ_LAT];
  logic [DATA_W-1:0]   pipe_dat_d [READ_LAT];

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we;
  logic [IDX_W-1:0]    mem_widx;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_wmask;

  logic                accept_c;
  logic                collide_c;
  logic                in_range_c;
  logic                wr_c;
  logic                rd_c;
  logic [IDX_W-1:0]    req_idx_c;
  logic [DATA_W-1:0]   rd_word_c;
  logic [DATA_W-1:0]   lane_mask_c;

  // Range check collapses to constant-true when the address space fits exactly.
  if (DEPTH >= (2 ** ADDR_W)) begin : g_full_range
    assign in_range_c = 1'b1;
  end else begin : g_part_range
    assign in_range_c = (32'(req_addr) < DEPTH);
  end

  // FSM state register.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // FSM next state: sweep one word per cycle, then idle forever.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: handshake/busy from the upcoming state, and the memory write port mux.
  always_comb begin
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d == ST_CLEAR);
    mem_we      = 1'b0;
    mem_widx    = req_idx_c;
    mem_wdata   = req_wdata;
    mem_wmask   = lane_mask_c;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_widx  = ptr_q;
      mem_wdata = INIT_WORD;
      mem_wmask = '1;
    end else if (wr_c) begin
      mem_we    = 1'b1;
    end
  end

  // Request decode: a collision suppresses both the write and the read.
  always_comb begin
    accept_c  = req_valid & req_ready_q;
    collide_c = accept_c & req_rd & req_wr;
    wr_c      = accept_c & req_wr & ~req_rd & in_range_c;
    rd_c      = accept_c & req_rd & ~req_wr;
    req_idx_c = req_addr[IDX_W-1:0];
    rd_word_c = in_range_c ? mem_q[req_idx_c] : INIT_WORD;
    lane_mask_c = '0;
    for (int b = 0; b < int'(DATA_W); b++) begin
      lane_mask_c[b] = req_be[b / 8];
    end
  end

  // Storage array; deliberately not reset so contents survive SIM_RST.
  always_ff @(posedge SIM_CLK) begin
    if (mem_we) begin
      mem_q[mem_widx] <= (mem_q[mem_widx] & ~mem_wmask) | (mem_wdata & mem_wmask);
    end
  end

  // Read return pipeline and sticky error next-state.
  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_dat_d    = pipe_dat_q;
    pipe_vld_d[0] = rd_c;
    if (rd_c) begin
      pipe_dat_d[0] = rd_word_c;
    end
    for (int i = 1; i < int'(READ_LAT); i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_dat_d[i] = pipe_dat_q[i-1];
    end
    rdata_valid_d = pipe_vld_q[LAST];
    rdata_d       = pipe_vld_q[LAST] ? pipe_dat_q[LAST] : rdata_q;
    // Set has priority over clear.
    err_collide_d = collide_c | (err_collide_q & ~err_clr);
    err_range_d   = (accept_c & (req_rd | req_wr) & ~in_range_c) | (err_range_q & ~err_clr);
  end

  // Output and pipeline registers.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      req_ready_q   <= 1'b0;
      busy_q        <= (CLEAR_ON_RESET != 0);
      err_collide_q <= 1'b0;
      err_range_q   <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      pipe_vld_q    <= '0;
      for (int i = 0; i < int'(READ_LAT); i++) begin
        pipe_dat_q[i] <= '0;
      end
    end else begin
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      err_collide_q <= err_collide_d;
      err_range_q   <= err_range_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      pipe_vld_q    <= pipe_vld_d;
      pipe_dat_q    <= pipe_dat_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign busy        = busy_q;
  assign err_collide = err_collide_q;
  assign err_range   = err_range_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_erasable_ram_sync.sv
// Bench for erasable_ram_sync: one default instance (2048 words, latency 1) and one
// small instance (1000 words, 10-bit address, latency 3). Reads push the model's
// expected word and due cycle onto a per-instance queue; a negedge monitor pops and
// compares whenever rdata_valid pulses.
module tb_erasable_ram_sync;

  localparam logic [15:0] INIT = 16'o40000;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  logic [1:0]        rst, valid, rd, wr, clr;
  logic [1:0][10:0]  addr;
  logic [1:0][15:0]  wdata;
  logic [1:0][1:0]   be;

  logic        ready0, rvalid0, busy0, ecol0, erng0;
  logic        ready1, rvalid1, busy1, ecol1, erng1;
  logic [15:0] rdata0, rdata1;

  logic [15:0] model [2][2048];
  exp_t        q0 [$];
  exp_t        q1 [$];
  int          depth_k [2] = '{2048, 1000};
  int          lat_k   [2] = '{1, 3};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  erasable_ram_sync u_big (
    .SIM_CLK(clk), .SIM_RST(rst[0]),
    .req_valid(valid[0]), .req_ready(ready0), .req_rd(rd[0]), .req_wr(wr[0]),
    .req_addr(addr[0]), .req_wdata(wdata[0]), .req_be(be[0]),
    .rdata(rdata0), .rdata_valid(rvalid0), .busy(busy0),
    .err_collide(ecol0), .err_range(erng0), .err_clr(clr[0])
  );

  erasable_ram_sync #(.DEPTH(1000), .ADDR_W(10), .READ_LAT(3)) u_small (
    .SIM_CLK(clk), .SIM_RST(rst[1]),
    .req_valid(valid[1]), .req_ready(ready1), .req_rd(rd[1]), .req_wr(wr[1]),
    .req_addr(addr[1][9:0]), .req_wdata(wdata[1]), .req_be(be[1]),
    .rdata(rdata1), .rdata_valid(rvalid1), .busy(busy1),
    .err_collide(ecol1), .err_range(erng1), .err_clr(clr[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pop and compare one expected read whenever an instance pulses rdata_valid.
  task automatic mon(input int k);
    logic        v;
    logic [15:0] d;
    exp_t        e;
    v = (k == 0) ? rvalid0 : rvalid1;
    d = (k == 0) ? rdata0 : rdata1;
    if (v) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        check($sformatf("unexpected_rvalid%0d", k), 32'(v), 32'd0);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("rdata%0d", k), 32'(d), 32'(e.data));
        check($sformatf("rlat%0d", k), 32'(cyc), 32'(e.due));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Present one request for one accept edge and update the model/scoreboard.
  task automatic req(input int k, input logic r, input logic w, input int a,
                     input logic [15:0] d, input logic [1:0] b);
    exp_t        e;
    logic [15:0] m;
    @(negedge clk);
    valid[k] = 1'b1; rd[k] = r; wr[k] = w;
    addr[k] = 11'(a); wdata[k] = d; be[k] = b;
    check($sformatf("ready%0d", k), 32'((k == 0) ? ready0 : ready1), 32'd1);
    @(posedge clk);
    #1;
    if (r && !w) begin
      e.data = (a < depth_k[k]) ? model[k][a] : INIT;
      e.due  = cyc + lat_k[k];
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end else if (w && !r && a < depth_k[k]) begin
      m = model[k][a];
      if (b[0]) m[7:0]  = d[7:0];
      if (b[1]) m[15:8] = d[15:8];
      model[k][a] = m;
    end
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    valid[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0;
  endtask

  // Count cycles until busy drops; ready must stay low throughout.
  task automatic sweep(input int k, input int exp_len);
    int n;
    int bad;
    n = 0; bad = 0;
    while (((k == 0) ? busy0 : busy1) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
      if (((k == 0) ? busy0 : busy1) && ((k == 0) ? ready0 : ready1)) bad++;
    end
    check($sformatf("sweep_len%0d", k), 32'(n), 32'(exp_len));
    check($sformatf("ready_in_sweep%0d", k), 32'(bad), 32'd0);
    for (int i = 0; i < 2048; i++) model[k][i] = INIT;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_q0", 32'(q0.size()), 32'd0);
    check("drain_q1", 32'(q1.size()), 32'd0);
  endtask

  initial begin
    rst = 2'b11; valid = '0; rd = '0; wr = '0; clr = '0;
    addr = '0; wdata = '0; be = '0;
    repeat (3) @(negedge clk);

    // Reset state of the default instance.
    check("rst_busy", 32'(busy0), 32'd1);
    check("rst_ready", 32'(ready0), 32'd0);
    check("rst_rvalid", 32'(rvalid0), 32'd0);
    check("rst_rdata", 32'(rdata0), 32'd0);
    check("rst_errs", 32'({ecol0, erng0}), 32'd0);

    // Sweep length and initial contents.
    rst[0] = 1'b0;
    sweep(0, 2048);
    req(0, 1, 0, 0, 16'h0, 2'b00);
    req(0, 1, 0, 1023, 16'h0, 2'b00);
    req(0, 1, 0, 2047, 16'h0, 2'b00);
    idle(0);
    drain();

    // Full write then read on the very next edge.
    req(0, 0, 1, 5, 16'hA55A, 2'b11);
    req(0, 1, 0, 5, 16'h0, 2'b00);
    // Lane-masked writes.
    req(0, 0, 1, 5, 16'h1234, 2'b01);
    req(0, 1, 0, 5, 16'h0, 2'b00);
    req(0, 0, 1, 5, 16'hFF00, 2'b10);
    req(0, 1, 0, 5, 16'h0, 2'b00);
    req(0, 0, 1, 6, 16'hBEEF, 2'b00);
    req(0, 1, 0, 6, 16'h0, 2'b00);
    idle(0);
    drain();

    // Collision: no write, no read pulse, sticky flag; clear; set beats clear.
    req(0, 1, 1, 7, 16'h0001, 2'b11);
    idle(0);
    check("err_collide_set", 32'(ecol0), 32'd1);
    req(0, 1, 0, 7, 16'h0, 2'b00);
    idle(0);
    drain();
    check("err_collide_hold", 32'(ecol0), 32'd1);
    clr[0] = 1'b1;
    @(posedge clk); #1;
    clr[0] = 1'b0;
    check("err_collide_clr", 32'(ecol0), 32'd0);
    clr[0] = 1'b1;
    req(0, 1, 1, 7, 16'h0002, 2'b11);
    clr[0] = 1'b0;
    idle(0);
    check("err_collide_setwins", 32'(ecol0), 32'd1);
    clr[0] = 1'b1;
    @(posedge clk); #1;
    clr[0] = 1'b0;
    // Neither rd nor wr: accepted and ignored.
    req(0, 0, 0, 9, 16'h5555, 2'b11);
    req(0, 1, 0, 9, 16'h0, 2'b00);
    idle(0);
    drain();
    check("noop_errs", 32'({ecol0, erng0}), 32'd0);

    // Small instance: sweep, then latency-3 back-to-back reads.
    rst[1] = 1'b0;
    sweep(1, 1000);
    req(1, 0, 1, 1, 16'h1111, 2'b11);
    req(1, 0, 1, 2, 16'h2222, 2'b11);
    req(1, 0, 1, 3, 16'h3333, 2'b11);
    req(1, 1, 0, 1, 16'h0, 2'b00);
    req(1, 1, 0, 2, 16'h0, 2'b00);
    req(1, 1, 0, 3, 16'h0, 2'b00);
    idle(1);
    drain();

    // Out of range write discarded, read returns INIT, sticky range flag.
    req(1, 0, 1, 1010, 16'h7777, 2'b11);
    idle(1);
    check("err_range_set", 32'(erng1), 32'd1);
    req(1, 1, 0, 1010, 16'h0, 2'b00);
    req(1, 0, 1, 600, 16'h0BAD, 2'b11);
    req(1, 1, 0, 600, 16'h0, 2'b00);
    idle(1);
    drain();

    // Reset with a read in flight drops its pulse.
    req(1, 1, 0, 600, 16'h0, 2'b00);
    idle(1);
    rst[1] = 1'b1;
    q1.delete();
    repeat (5) @(negedge clk);
    check("rst_err_range", 32'(erng1), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd1);

    // Reset mid-sweep at pointer 500 restarts the full sweep.
    rst[1] = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    check("mid_sweep_busy", 32'(busy1), 32'd1);
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    sweep(1, 1000);
    req(1, 1, 0, 600, 16'h0, 2'b00);
    req(1, 1, 0, 2, 16'h0, 2'b00);
    idle(1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
